// File: rtl/regfft_reorder_pkg.sv
// Shared types, default sizes and the bit-reverse helper for the FFT reorder block.
package regfft_reorder_pkg;

   localparam int unsigned ADDR_W_DEF   = 6;
   localparam int unsigned DATA_W_DEF   = 38;
   localparam int unsigned BITREV_MAX_W = 16;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // Reverse the low w bits of x; bits at and above w come back as zero.
   function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] x,
                                                      input int unsigned w);
      logic [BITREV_MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
         if (i < w) r[i] = x[w-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/regfft_reorder_skid.sv
// Two-entry output FIFO: head entry drives the output and holds while stalled, tail absorbs one extra beat.
module regfft_reorder_skid #(
   parameter int unsigned W = 39
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [1:0]   count,
   output logic [W-1:0] head
);

   logic [1:0]   count_q, count_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) head_d = push_data;
            else                 tail_d = push_data;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            // Simultaneous push/pop: the tail (if any) advances, the new beat fills behind it.
            if (count_q == 2'd2) begin
               head_d = tail_q;
               tail_d = push_data;
            end else begin
               head_d = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= 2'd0;
      else     count_q <= count_d;
   end

   always_ff @(posedge clk) begin
      head_q <= head_d;
      tail_q <= tail_d;
   end

   assign count = count_q;
   assign head  = head_q;

endmodule

// File: rtl/regfft_reorder.sv
// Loads one frame into regfftr at bit-reversed addresses, then drains it in natural order with backpressure.
module regfft_reorder
   import regfft_reorder_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              frame_err,
   output logic              regfft_wren,
   output logic [ADDR_W-1:0] regfft_addr,
   output logic [DATA_W-1:0] regfft_din,
   input  logic [DATA_W-1:0] regfft_dout
);

   localparam int unsigned SKID_W = DATA_W + 1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
   logic [ADDR_W-1:0]   rcnt_q, rcnt_d;
   logic                rd_done_q, rd_done_d;
   logic                inflight_q, inflight_d;
   logic                rd_last_q, rd_last_d;
   logic                frame_err_q, frame_err_d;

   logic [1:0]          skid_count;
   logic [SKID_W-1:0]   skid_head;
   logic                in_hs;
   logic                pop;
   logic                issue;
   logic [2:0]          credit;

   // Outputs are masked during reset so nothing handshakes on stale state.
   assign out_valid = (skid_count != 2'd0) && !rst;
   assign out_data  = skid_head[DATA_W-1:0];
   assign out_last  = skid_head[DATA_W] && out_valid;
   assign frame_err = frame_err_q && !rst;
   assign in_ready  = (state_q == ST_FILL) && !rst;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      rd_done_d   = rd_done_q;
      frame_err_d = 1'b0;
      issue       = 1'b0;
      regfft_wren = 1'b0;
      regfft_addr = rcnt_q;
      regfft_din  = in_data;
      in_hs       = in_valid && in_ready;
      // Entries held plus the read landing next cycle, less the one leaving now.
      credit      = 3'(skid_count) + 3'(inflight_q) - 3'(pop);
      case (state_q)
         ST_FILL: begin
            regfft_addr = ADDR_W'(bitrev(BITREV_MAX_W'(wcnt_q), ADDR_W));
            if (in_hs) begin
               regfft_wren = 1'b1;
               wcnt_d      = wcnt_q + ADDR_W'(1);
               frame_err_d = in_last != (wcnt_q == '1);
               if (wcnt_q == '1) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            issue = !rd_done_q && (credit < 3'd2);
            if (issue) begin
               rcnt_d = rcnt_q + ADDR_W'(1);
               if (rcnt_q == '1) rd_done_d = 1'b1;
            end
            if (pop && out_last) begin
               state_d   = ST_FILL;
               rcnt_d    = '0;
               rd_done_d = 1'b0;
            end
         end
         default: state_d = ST_FILL;
      endcase
      inflight_d = issue;
      rd_last_d  = (rcnt_q == '1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FILL;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         rd_done_q   <= 1'b0;
         inflight_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         rd_done_q   <= rd_done_d;
         inflight_q  <= inflight_d;
         rd_last_q   <= rd_last_d;
         frame_err_q <= frame_err_d;
      end
   end

   regfft_reorder_skid #(.W(SKID_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data ({rd_last_q, regfft_dout}),
      .pop       (pop),
      .count     (skid_count),
      .head      (skid_head)
   );

endmodule

// File: tb/tb_regfft_reorder.sv
// Directed bench for regfft_reorder with a behavioural regfftr (registered read port) alongside.
module tb_regfft_reorder;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 38;
   localparam int N = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, in_last;
   logic [DW-1:0] in_data;
   logic          out_valid, out_ready, out_last, frame_err;
   logic [DW-1:0] out_data;
   logic          regfft_wren;
   logic [AW-1:0] regfft_addr;
   logic [DW-1:0] regfft_din, regfft_dout;

   logic [DW-1:0] mem [N];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [DW-1:0] out_q [$];
   logic          last_q [$];
   int            pop_cyc [$];
   logic [AW-1:0] wr_q [$];
   int            err_cyc [$];
   int            hs_cyc [N];
   int            first_valid_cyc = -1;
   int            stall_viol = 0;
   int            overlap = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   always #5 clk = ~clk;

   regfft_reorder #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .frame_err   (frame_err),
      .regfft_wren (regfft_wren),
      .regfft_addr (regfft_addr),
      .regfft_din  (regfft_din),
      .regfft_dout (regfft_dout)
   );

   always @(posedge clk) begin
      if (regfft_wren) mem[regfft_addr] <= regfft_din;
      regfft_dout <= mem[regfft_addr];
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         out_q.push_back(out_data);
         last_q.push_back(out_last);
         pop_cyc.push_back(cyc);
      end
      if (regfft_wren) wr_q.push_back(regfft_addr);
      if (frame_err) err_cyc.push_back(cyc);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
         stall_viol++;
      if (in_ready && out_valid) overlap++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
   end

   function automatic int tb_bitrev(input int k);
      int r = 0;
      for (int i = 0; i < 6; i++) if (((k >> i) & 1) != 0) r |= (1 << (5 - i));
      return r;
   endfunction

   task automatic clear_mon();
      out_q.delete(); last_q.delete(); pop_cyc.delete(); wr_q.delete(); err_cyc.delete();
      first_valid_cyc = -1;
      stall_viol = 0;
      overlap = 0;
   endtask

   task automatic send_frame(input int base, input int last_idx, input bit gaps, output bit done);
      int k = 0;
      int guard = 0;
      while (k < N && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
         if (gaps && $urandom_range(0, 1) == 0) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = DW'(base + k);
            in_last  = (k == last_idx);
            if (in_ready) begin
               hs_cyc[k] = cyc;
               k++;
            end
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      done = (k == N);
   endtask

   task automatic drain(input int nbeats, input int mode, output bit done);
      int guard = 0;
      while (out_q.size() < nbeats && guard < 3000) begin
         @(posedge clk); #1;
         guard++;
         case (mode)
            1:       out_ready = guard[0];
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
      end
      done = (out_q.size() >= nbeats);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || frame_err !== 1'b0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: in_ready=%b out_valid=%b frame_err=%b out_last=%b, required all 0",
                  in_ready, out_valid, frame_err, out_last);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || regfft_wren !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b wren=%b, required 1 0 0",
                  in_ready, out_valid, regfft_wren);
      end
   endtask

   task automatic test_ramp();
      bit ok_s, ok_d;
      logic [DW-1:0] head_exp [8] = '{0, 32, 16, 48, 8, 40, 24, 56};
      clear_mon();
      out_ready = 1'b1;
      send_frame(0, 63, 1'b0, ok_s);
      drain(N, 0, ok_d);
      checks++;
      if (!ok_s || !ok_d || out_q.size() != N) begin
         errors++;
         $display("FAIL ramp_count: sent=%b beats=%0d, required 64", ok_s, out_q.size());
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_q[k] !== head_exp[k]) begin
               errors++;
               $display("FAIL ramp_beat%0d: got %0d, required %0d", k, out_q[k], head_exp[k]);
            end
         end
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_q[k] !== DW'(tb_bitrev(k)) || last_q[k] !== (k == N - 1)) begin
               errors++;
               $display("FAIL ramp_order beat %0d: got %0d last=%b, required %0d last=%b",
                        k, out_q[k], last_q[k], tb_bitrev(k), (k == N - 1));
            end
         end
         checks++;
         if (first_valid_cyc - hs_cyc[63] != 3) begin
            errors++;
            $display("FAIL ramp_latency: got %0d cycles, required 3", first_valid_cyc - hs_cyc[63]);
         end
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ramp_back_to_fill: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_backpressure(input int mode);
      bit ok_s, ok_d;
      clear_mon();
      out_ready = 1'b0;
      send_frame(0, 63, 1'b0, ok_s);
      drain(N, mode, ok_d);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (!ok_s || !ok_d || out_q.size() != N) begin
         errors++;
         $display("FAIL bp%0d_count: beats=%0d, required 64", mode, out_q.size());
      end else begin
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_q[k] !== DW'(tb_bitrev(k)) || last_q[k] !== (k == N - 1)) begin
               errors++;
               $display("FAIL bp%0d_order beat %0d: got %0d, required %0d", mode, k, out_q[k], tb_bitrev(k));
            end
         end
      end
      checks++;
      if (stall_viol != 0) begin
         errors++;
         $display("FAIL bp%0d_stable: %0d unstable stall cycles, required 0", mode, stall_viol);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_frame_err();
      bit ok_s, ok_d;
      clear_mon();
      out_ready = 1'b1;
      send_frame(0, 10, 1'b0, ok_s);
      drain(N, 0, ok_d);
      checks++;
      if (err_cyc.size() != 2) begin
         errors++;
         $display("FAIL frame_err_count: got %0d pulses, required 2", err_cyc.size());
      end else begin
         checks++;
         if (err_cyc[0] != hs_cyc[10] + 1 || err_cyc[1] != hs_cyc[63] + 1) begin
            errors++;
            $display("FAIL frame_err_timing: got cycles %0d,%0d, required %0d,%0d",
                     err_cyc[0], err_cyc[1], hs_cyc[10] + 1, hs_cyc[63] + 1);
         end
      end
      checks++;
      if (!ok_d || out_q.size() != N || out_q[63] !== DW'(63)) begin
         errors++;
         $display("FAIL frame_err_drain: beats=%0d, required 64", out_q.size());
      end
   endtask

   task automatic test_mid_reset();
      bit ok_s, ok_d;
      clear_mon();
      out_ready = 1'b1;
      send_frame(0, 63, 1'b0, ok_s);
      drain(21, 0, ok_d);
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_during: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst_after: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      end
      clear_mon();
      send_frame(0, 63, 1'b0, ok_s);
      drain(N, 0, ok_d);
      checks++;
      if (!ok_d || out_q.size() != N) begin
         errors++;
         $display("FAIL midrst_refill: beats=%0d, required 64", out_q.size());
      end else begin
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_q[k] !== DW'(tb_bitrev(k))) begin
               errors++;
               $display("FAIL midrst_order beat %0d: got %0d, required %0d", k, out_q[k], tb_bitrev(k));
            end
         end
      end
   endtask

   task automatic test_gaps();
      bit ok_s, ok_d;
      clear_mon();
      out_ready = 1'b1;
      send_frame(0, 63, 1'b1, ok_s);
      drain(N, 0, ok_d);
      checks++;
      if (!ok_s || wr_q.size() != N) begin
         errors++;
         $display("FAIL gaps_writes: got %0d writes, required 64", wr_q.size());
      end else begin
         for (int k = 0; k < N; k++) begin
            checks++;
            if (wr_q[k] !== AW'(tb_bitrev(k))) begin
               errors++;
               $display("FAIL gaps_addr write %0d: got %0d, required %0d", k, wr_q[k], tb_bitrev(k));
            end
         end
      end
      checks++;
      if (!ok_d || out_q.size() != N) begin
         errors++;
         $display("FAIL gaps_count: beats=%0d, required 64", out_q.size());
      end else begin
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_q[k] !== DW'(tb_bitrev(k))) begin
               errors++;
               $display("FAIL gaps_order beat %0d: got %0d, required %0d", k, out_q[k], tb_bitrev(k));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok_s1, ok_s2, ok_d;
      clear_mon();
      out_ready = 1'b1;
      send_frame(0, 63, 1'b0, ok_s1);
      send_frame(100, 63, 1'b0, ok_s2);
      drain(2 * N, 0, ok_d);
      checks++;
      if (!ok_s2 || !ok_d || out_q.size() != 2 * N) begin
         errors++;
         $display("FAIL b2b_count: beats=%0d, required 128", out_q.size());
      end else begin
         checks++;
         if (out_q[N + 1] !== DW'(132)) begin
            errors++;
            $display("FAIL b2b_f2_beat1: got %0d, required 132", out_q[N + 1]);
         end
         checks++;
         if (hs_cyc[0] != pop_cyc[N - 1] + 1) begin
            errors++;
            $display("FAIL b2b_ready_rise: first f2 handshake cycle %0d, required %0d",
                     hs_cyc[0], pop_cyc[N - 1] + 1);
         end
         for (int k = 0; k < N; k++) begin
            checks++;
            if (out_q[k] !== DW'(tb_bitrev(k)) || out_q[N + k] !== DW'(100 + tb_bitrev(k))) begin
               errors++;
               $display("FAIL b2b_order beat %0d: got %0d/%0d, required %0d/%0d", k,
                        out_q[k], out_q[N + k], tb_bitrev(k), 100 + tb_bitrev(k));
            end
         end
      end
      checks++;
      if (overlap != 0) begin
         errors++;
         $display("FAIL b2b_in_ready_low: %0d cycles with in_ready during drain, required 0", overlap);
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_backpressure(1);
      test_backpressure(2);
      test_frame_err();
      test_mid_reset();
      test_gaps();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
